mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for a small MIPS-subset datapath.
//
// Sequences each instruction through FETCH / DECODE / EXE / MEM / WB / BR
// and drives the datapath enables and mux selects combinationally from the
// current state and the registered instruction fields.
//
// Ports
//   clk     in   sole clock, rising edge
//   reset   in   synchronous, active-high; forces FETCH, masks write enables
//   op      in   [5:0] instr[31:26] from the registered IR
//   func    in   [5:0] instr[5:0] from the registered IR
//   zero    in   ALU equality flag (A==B), used only in BR
//   PCWr    out  PC write enable
//   IRWr    out  IR write enable
//   RFWr    out  register file write enable
//   DMWr    out  data memory write enable
//   M3Sel   out  ALU B select: 0 rt data, 1 extender output
//   ExtOp   out  0 zero-extend, 1 sign-extend imm16
//   ALUOp   out  [2:0] 000 add, 001 sub, 010 or, 011 lui
//   RegDst  out  [1:0] 0 rt, 1 rd, 2 $31
//   WDSel   out  [1:0] 0 ALU, 1 DM, 2 PC
//   NPCOp   out  [1:0] 0 PC+4, 1 branch, 2 j, 3 jr
//   state   out  [2:0] current FSM state (debug)
//
// Handshake: none; the controller free-runs one state per clock and the
// datapath acts on every enable in the cycle it is asserted.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic       M3Sel,
  output logic       ExtOp,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Instruction decode; anything unmatched is treated as a nop.
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_alu, is_mem;

  assign is_r    = (op == 6'b000000);
  assign is_addu = is_r && (func == 6'b100001);
  assign is_subu = is_r && (func == 6'b100011);
  assign is_jr   = is_r && (func == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_alu  = is_addu | is_subu | is_ori | is_lui;
  assign is_mem  = is_lw | is_sw;

  // ALU controls for the instruction; applied from EXE through WB so the
  // ALU result stays stable while MEM/WB consume it.
  logic [2:0] alu_op_c;
  logic       alu_m3_c, alu_ext_c;

  always_comb begin
    alu_op_c  = 3'b000;
    alu_m3_c  = 1'b0;
    alu_ext_c = 1'b0;
    if (is_subu) begin
      alu_op_c = 3'b001;
    end else if (is_ori) begin
      alu_op_c = 3'b010;
      alu_m3_c = 1'b1;
    end else if (is_lui) begin
      alu_op_c = 3'b011;
      alu_m3_c = 1'b1;
    end else if (is_mem) begin
      alu_m3_c  = 1'b1;
      alu_ext_c = 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    M3Sel   = 1'b0;
    ExtOp   = 1'b0;
    ALUOp   = 3'b000;
    RegDst  = 2'd0;
    WDSel   = 2'd0;
    NPCOp   = 2'd0;

    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          PCWr  = 1'b1;
          NPCOp = 2'd2;
        end else if (is_jal) begin
          PCWr   = 1'b1;
          NPCOp  = 2'd2;
          RFWr   = 1'b1;
          RegDst = 2'd2;
          WDSel  = 2'd2;
        end else if (is_jr) begin
          PCWr  = 1'b1;
          NPCOp = 2'd3;
        end else if (is_beq) begin
          state_d = S_BR;
        end else if (is_alu || is_mem) begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_alu || is_mem) begin
          ALUOp = alu_op_c;
          M3Sel = alu_m3_c;
          ExtOp = alu_ext_c;
        end
        if (is_mem)      state_d = S_MEM;
        else if (is_alu) state_d = S_WB;
      end
      S_MEM: begin
        if (is_mem) begin
          ALUOp = alu_op_c;
          M3Sel = alu_m3_c;
          ExtOp = alu_ext_c;
          DMWr  = is_sw;
          if (is_lw) state_d = S_WB;
        end
      end
      S_WB: begin
        if (is_alu || is_lw) begin
          ALUOp  = alu_op_c;
          M3Sel  = alu_m3_c;
          ExtOp  = alu_ext_c;
          RFWr   = 1'b1;
          RegDst = (is_addu || is_subu) ? 2'd1 : 2'd0;
          WDSel  = is_lw ? 2'd1 : 2'd0;
        end
      end
      S_BR: begin
        ALUOp = 3'b001;
        ExtOp = 1'b1;
        NPCOp = 2'd1;
        PCWr  = zero;
      end
      default: begin
        // Unused codes 6/7: recover to FETCH with nothing asserted.
      end
    endcase

    // Reset masks every architectural write in the same cycle.
    if (reset) begin
      PCWr = 1'b0;
      IRWr = 1'b0;
      RFWr = 1'b0;
      DMWr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       PCWr, IRWr, RFWr, DMWr, M3Sel, ExtOp;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, WDSel, NPCOp;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  string       name_q[$];

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .M3Sel(M3Sel), .ExtOp(ExtOp), .ALUOp(ALUOp), .RegDst(RegDst),
    .WDSel(WDSel), .NPCOp(NPCOp), .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Packed view: {state, PCWr, IRWr, RFWr, DMWr, M3Sel, ExtOp, ALUOp, RegDst, WDSel, NPCOp}
  function automatic logic [17:0] ev(input int s, input bit pc, input bit ir, input bit rf,
                                     input bit dm, input bit m3, input bit ex, input int alu,
                                     input int rd, input int wd, input int np);
    return {3'(s), pc, ir, rf, dm, m3, ex, 3'(alu), 2'(rd), 2'(wd), 2'(np)};
  endfunction

  // Driver: one call per clock cycle; inputs applied after the edge and the
  // hand-computed outputs for that cycle queued for the monitor.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = r; op = o; func = f; zero = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Scoreboard monitor: samples on the falling edge, pops and compares.
  logic [17:0] mon_exp, mon_act;
  string       mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {state, PCWr, IRWr, RFWr, DMWr, M3Sel, ExtOp, ALUOp, RegDst, WDSel, NPCOp};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL %s: got st=%0d pc/ir/rf/dm=%b m3/ex=%b alu=%b rd=%0d wd=%0d np=%0d, expected st=%0d pc/ir/rf/dm=%b m3/ex=%b alu=%b rd=%0d wd=%0d np=%0d",
                 mon_nm, mon_act[17:15], mon_act[14:11], mon_act[10:9], mon_act[8:6],
                 mon_act[5:4], mon_act[3:2], mon_act[1:0],
                 mon_exp[17:15], mon_exp[14:11], mon_exp[10:9], mon_exp[8:6],
                 mon_exp[5:4], mon_exp[3:2], mon_exp[1:0]);
      end
    end
  end

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;

  logic [17:0] e_f, e_d0, e_rst;

  initial begin
    e_f   = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_d0  = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_rst = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset for two cycles: FETCH with all enables masked
    cyc(1, OP_R, F_ADDU, 0, e_rst, "reset1");
    cyc(1, OP_R, F_ADDU, 0, e_rst, "reset2");

    // addu: 0,1,2,4,0
    cyc(0, OP_R, F_ADDU, 0, e_f,  "addu_fetch");
    cyc(0, OP_R, F_ADDU, 0, e_d0, "addu_decode");
    cyc(0, OP_R, F_ADDU, 0, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addu_exe");
    cyc(0, OP_R, F_ADDU, 0, ev(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "addu_wb");

    // subu
    cyc(0, OP_R, F_SUBU, 0, e_f,  "subu_fetch");
    cyc(0, OP_R, F_SUBU, 0, e_d0, "subu_decode");
    cyc(0, OP_R, F_SUBU, 0, ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "subu_exe");
    cyc(0, OP_R, F_SUBU, 0, ev(4, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0), "subu_wb");

    // lw: 0,1,2,3,4,0
    cyc(0, OP_LW, 6'd0, 0, e_f,  "lw_fetch");
    cyc(0, OP_LW, 6'd0, 0, e_d0, "lw_decode");
    cyc(0, OP_LW, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "lw_exe");
    cyc(0, OP_LW, 6'd0, 0, ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "lw_mem");
    cyc(0, OP_LW, 6'd0, 0, ev(4, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0), "lw_wb");

    // ori, lui
    cyc(0, OP_ORI, 6'd0, 0, e_f,  "ori_fetch");
    cyc(0, OP_ORI, 6'd0, 0, e_d0, "ori_decode");
    cyc(0, OP_ORI, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0), "ori_exe");
    cyc(0, OP_ORI, 6'd0, 0, ev(4, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0), "ori_wb");
    cyc(0, OP_LUI, 6'd0, 0, e_f,  "lui_fetch");
    cyc(0, OP_LUI, 6'd0, 0, e_d0, "lui_decode");
    cyc(0, OP_LUI, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0), "lui_exe");
    cyc(0, OP_LUI, 6'd0, 0, ev(4, 0, 0, 1, 0, 1, 0, 3, 0, 0, 0), "lui_wb");

    // beq taken then not taken: 3 cycles each
    cyc(0, OP_BEQ, 6'd0, 1, e_f,  "beq1_fetch");
    cyc(0, OP_BEQ, 6'd0, 1, e_d0, "beq1_decode");
    cyc(0, OP_BEQ, 6'd0, 1, ev(5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1), "beq1_br_taken");
    cyc(0, OP_BEQ, 6'd0, 0, e_f,  "beq2_fetch");
    cyc(0, OP_BEQ, 6'd0, 0, e_d0, "beq2_decode");
    cyc(0, OP_BEQ, 6'd0, 0, ev(5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), "beq2_br_not_taken");

    // jal, j, jr: 2 cycles each
    cyc(0, OP_JAL, 6'd0, 0, e_f, "jal_fetch");
    cyc(0, OP_JAL, 6'd0, 0, ev(1, 1, 0, 1, 0, 0, 0, 0, 2, 2, 2), "jal_decode");
    cyc(0, OP_J, 6'd0, 0, e_f, "j_fetch");
    cyc(0, OP_J, 6'd0, 0, ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2), "j_decode");
    cyc(0, OP_R, F_JR, 0, e_f, "jr_fetch");
    cyc(0, OP_R, F_JR, 0, ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3), "jr_decode");

    // sw full: 0,1,2,3,0 with DMWr in MEM
    cyc(0, OP_SW, 6'd0, 0, e_f,  "sw_fetch");
    cyc(0, OP_SW, 6'd0, 0, e_d0, "sw_decode");
    cyc(0, OP_SW, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "sw_exe");
    cyc(0, OP_SW, 6'd0, 0, ev(3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), "sw_mem");

    // sw with reset during MEM: DMWr masked, FETCH next
    cyc(0, OP_SW, 6'd0, 0, e_f,  "swr_fetch");
    cyc(0, OP_SW, 6'd0, 0, e_d0, "swr_decode");
    cyc(0, OP_SW, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "swr_exe");
    cyc(1, OP_SW, 6'd0, 0, ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "swr_mem_reset");
    cyc(0, OP_SW, 6'd0, 0, e_f,  "swr_after_reset");

    // illegal op: 0,1,0 with no enables in DECODE
    cyc(0, OP_BAD, 6'd0, 0, e_d0, "bad_decode");
    cyc(0, OP_BAD, 6'd0, 0, e_f,  "bad_back_to_fetch");
    // R-type with unknown func is also a nop
    cyc(0, OP_R, 6'b111111, 0, e_d0, "rnop_decode");

    // lw with reset during WB: RFWr masked, FETCH next
    cyc(0, OP_LW, 6'd0, 0, e_f,  "lwr_fetch");
    cyc(0, OP_LW, 6'd0, 0, e_d0, "lwr_decode");
    cyc(0, OP_LW, 6'd0, 0, ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "lwr_exe");
    cyc(0, OP_LW, 6'd0, 0, ev(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "lwr_mem");
    cyc(1, OP_LW, 6'd0, 0, ev(4, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0), "lwr_wb_reset");
    cyc(0, OP_LW, 6'd0, 0, e_f,  "lwr_after_reset");

    // drain: the monitor pops on the next falling edge; bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
